pid_pwm_salida: RTL and testbench
=================================

Name: pid_pwm_salida

Overview:
- Output stage of the servo PID loop, directly downstream of the derivative stage.
- Adds the proportional, integral and derivative terms (signed fixed-point, N bits) and saturates the sum to ±LIMIT.
- Converts the result into a sign/magnitude PWM command (pwm_out plus dir_out) for the H-bridge.
- Duty changes only at PWM period boundaries, so the bridge never sees a glitched period.

Parameters:
- Magnitud, 18, integer bits of the fixed-point format.
- Decimal, 0, fractional bits of the fixed-point format.
- N, Magnitud+Decimal+1, total signed width of the P/I/D terms.
- PWM_PERIOD, 1000, clk cycles per PWM period.
- LIMIT, PWM_PERIOD, saturation bound in integer units. Must be ≤ PWM_PERIOD.
- DEADTIME, 20, blanking cycles after a direction change. Used only with PWM_DEADTIME_EN. Must be < PWM_PERIOD.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  one-cycle strobe: P/I/D terms are coherent this cycle.
- proporcional  in  N  signed P term.
- integral  in  N  signed I term.
- derivador  in  N  signed D term.
- pwm_out  out  1  PWM to the bridge enable.
- dir_out  out  1  1 = negative command.
- duty  out  CW  active duty in integer counts, where CW = clog2(PWM_PERIOD+1).
- saturado  out  1  last captured sum was clipped.
- periodo_fin  out  1  one-cycle pulse on the last cycle of each period.

Behaviour:
- Reset: synchronous, active-high, and it overrides every other input. All of the following are cleared: counter, shadow duty, active duty (duty), suma_sat, pwm_out, dir_out, saturado, periodo_fin. Reset mid-period restarts at counter=0 with pwm_out low.
- Sum: computed in N+2 bits, with no wrap possible. Saturated to [-LIMIT·2^Decimal, +LIMIT·2^Decimal].
- Capture on valid: suma_sat and saturado are registered one cycle after valid. Without valid, both hold their values.
- Shadow duty: the integer part of |suma_sat| (Decimal bits truncated). Shadow dir is the sign bit of suma_sat; a zero sum gives dir 0.
- Counter: runs 0..PWM_PERIOD-1 and wraps to 0.
- periodo_fin: high when counter == PWM_PERIOD-1.
- Period load: on the wrap cycle, duty <= shadow duty and dir_out <= shadow dir.
- Simultaneous valid and wrap: the wrap loads the shadow value as it was before this valid. The new command takes effect one period later.
- pwm_out: (counter < duty), from registers only. There is no combinational path from the inputs.
  - duty = 0 keeps pwm_out low for the whole period.
  - duty = PWM_PERIOD keeps pwm_out high for the whole period.
- Latency from valid to the first affected pwm_out cycle is between 2 and PWM_PERIOD+1 cycles, depending on the counter phase.
- Mode FSM:
  - States: RUN and BLANK.
  - Without the macro, the FSM stays in RUN.
  - With the macro, see Optional Feature.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - At a wrap where the newly loaded dir_out differs from the previous dir_out and the new duty is nonzero, the FSM enters BLANK.
  - In BLANK, pwm_out is forced low while counter < DEADTIME. The FSM returns to RUN when counter == DEADTIME.
  - Effective high time is max(duty, DEADTIME) - DEADTIME.
  - dir_out switches at the wrap regardless.
  - Reset returns the FSM to RUN.
- Undefined: no blanking. The FSM state register and DEADTIME logic are absent.

Decomposition:
- Shared package (pid_pkg) holds:
  - the fixed-point constants Magnitud/Decimal/N;
  - the saturation helper function (N+2 bits to bounded N bits);
  - the FSM state typedef {RUN, BLANK};
  - the CW width function.
- One natural sub-module, contador_pwm. It owns the period counter, periodo_fin and the wrap-load strobe, and is reusable by other PWM outputs.
- Summation, saturation and the shadow/active registers stay in the top level.

Test Plan:
- Basic command: reset, then valid with P=300, I=200, D=100. Next wrap: duty=600, dir_out=0, pwm_out high for exactly 600 of 1000 cycles, saturado=0.
- Positive saturation: P=900, I=200, D=0. saturado=1 one cycle after valid; duty=1000; pwm_out high for the whole period. Then P=900, I=-50, D=0 gives saturado=0 and duty=850 next period.
- Negative command: P=-250, I=0, D=0. After the wrap: dir_out=1, duty=250. A further command of -1000 gives duty=1000 with saturado=0 (at the bound, not clipped).
- Boundary timing: valid with sum 400 on the same cycle periodo_fin=1. The coming period keeps the old duty; duty=400 only from the following wrap. periodo_fin pulses every 1000 cycles, one cycle wide.
- Reset mid-operation: duty=600 running, assert reset at counter=300. Next cycle: pwm_out=0, duty=0, dir_out=0, counter=0. A valid issued during reset is ignored.
- PWM_DEADTIME_EN: command +500 then -500. At the sign-change wrap, pwm_out stays low for counter 0..19 and high for 20..499. A -300 → -300 repeat causes no blanking.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared fixed-point constants, saturation helper, mode FSM state type and
// duty-width function for the PID output stage.
package pid_pkg;

  localparam int Magnitud = 18;
  localparam int Decimal  = 0;
  localparam int N        = Magnitud + Decimal + 1;

  typedef enum logic {RUN, BLANK} modo_t;

  function automatic int cw_de(input int periodo);
    return $clog2(periodo + 1);
  endfunction

  // Clamp an N+2 bit sum to [-lim, +lim]; lim always fits in N bits.
  function automatic logic signed [N-1:0] saturar(input logic signed [N+1:0] x,
                                                  input logic signed [N+1:0] lim);
    logic signed [N+1:0] r;
    if (x > lim)
      r = lim;
    else if (x < -lim)
      r = -lim;
    else
      r = x;
    return r[N-1:0];
  endfunction

endpackage

// File: rtl/pid_pwm_salida_contador_pwm.sv
// Free-running PWM period counter with end-of-period pulse and load strobe,
// shared by any PWM output that needs period-aligned updates.
module contador_pwm
  import pid_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int CW         = cw_de(PWM_PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] contador,
  output logic          periodo_fin,
  output logic          carga
);

  localparam logic [CW-1:0] ULTIMO = CW'(PWM_PERIOD - 1);

  always_ff @(posedge clk) begin
    if (reset)
      contador <= '0;
    else if (periodo_fin)
      contador <= '0;
    else
      contador <= contador + 1'b1;
  end

  assign periodo_fin = (contador == ULTIMO);
  // The load happens on the same edge the counter wraps back to zero.
  assign carga       = periodo_fin;

endmodule

// File: rtl/pid_pwm_salida.sv
// PID output stage: P+I+D sum, saturation, and period-aligned sign/magnitude PWM.
// Optional direction-change blanking is enabled with `define PWM_DEADTIME_EN.
module pid_pwm_salida
  import pid_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int LIMIT      = PWM_PERIOD,
`ifdef PWM_DEADTIME_EN
  parameter int DEADTIME   = 20,
`endif
  parameter int CW         = cw_de(PWM_PERIOD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic signed [N-1:0] proporcional,
  input  logic signed [N-1:0] integral,
  input  logic signed [N-1:0] derivador,
  output logic                pwm_out,
  output logic                dir_out,
  output logic [CW-1:0]       duty,
  output logic                saturado,
  output logic                periodo_fin
);

  localparam logic signed [N+1:0] LIM_Q = (N+2)'(LIMIT * (2 ** Decimal));

  logic signed [N+1:0] suma_p0;
  logic signed [N-1:0] sat_p0;
  logic                clip_p0;
  logic signed [N-1:0] suma_sat_p1;
  logic [N-1:0]        mag_p1;
  logic [CW-1:0]       duty_sombra;
  logic                dir_sombra;
  logic [CW-1:0]       contador;
  logic                carga;

  // Stage p0: widened sum (three N-bit terms cannot overflow N+2 bits) and clamp
  assign suma_p0 = (N+2)'(proporcional) + (N+2)'(integral) + (N+2)'(derivador);
  assign sat_p0  = saturar(suma_p0, LIM_Q);
  assign clip_p0 = (suma_p0 > LIM_Q) || (suma_p0 < -LIM_Q);

  always_ff @(posedge clk) begin
    if (reset) begin
      suma_sat_p1 <= '0;
      saturado    <= 1'b0;
    end else if (valid) begin
      suma_sat_p1 <= sat_p0;
      saturado    <= clip_p0;
    end
  end

  // Stage p1: shadow command in sign/magnitude form
  assign mag_p1      = suma_sat_p1[N-1] ? -suma_sat_p1 : suma_sat_p1;
  assign duty_sombra = CW'(mag_p1 >> Decimal);
  assign dir_sombra  = suma_sat_p1[N-1];

  contador_pwm #(
    .PWM_PERIOD (PWM_PERIOD),
    .CW         (CW)
  ) u_contador (
    .clk         (clk),
    .reset       (reset),
    .contador    (contador),
    .periodo_fin (periodo_fin),
    .carga       (carga)
  );

  // Stage p2: active command, only updated at the period wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      duty    <= '0;
      dir_out <= 1'b0;
    end else if (carga) begin
      duty    <= duty_sombra;
      dir_out <= dir_sombra;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [CW-1:0] DT_C = CW'(DEADTIME);

  modo_t modo;

  always_ff @(posedge clk) begin
    if (reset)
      modo <= RUN;
    else begin
      case (modo)
        RUN:     if (carga && (dir_sombra != dir_out) && (duty_sombra != '0)) modo <= BLANK;
        BLANK:   if (contador == DT_C) modo <= RUN;
        default: modo <= RUN;
      endcase
    end
  end

  assign pwm_out = (contador < duty) && !((modo == BLANK) && (contador < DT_C));
`else
  assign pwm_out = (contador < duty);
`endif

endmodule

// File: tb/tb_pid_pwm_salida.sv
// Self-checking bench for pid_pwm_salida: vector table with a wrap-time
// scoreboard, plus period-boundary and mid-period reset sequences.
module tb_pid_pwm_salida;
  import pid_pkg::*;

  localparam int PER = 1000;
  localparam int CWB = cw_de(PER);
  localparam int DT  = 20;
`ifdef PWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                valid;
  logic signed [N-1:0] p, i, d;
  logic                pwm_out, dir_out, saturado, periodo_fin;
  logic [CWB-1:0]      duty;

  always #5 clk = ~clk;

  pid_pwm_salida #(
    .PWM_PERIOD (PER),
    .LIMIT      (PER)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .proporcional (p),
    .integral     (i),
    .derivador    (d),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .duty         (duty),
    .saturado     (saturado),
    .periodo_fin  (periodo_fin)
  );

  typedef struct {
    int pp; int ii; int dd;
    int duty; bit dir; bit sat;
  } vec_t;

  typedef struct {
    int duty; bit dir;
  } exp_t;

  vec_t tabla[15];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   prev_dir = 1'b0;

  task automatic check(input string nombre, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nombre, act, req);
    end
  endtask

  task automatic aplicar(input int pp, input int ii, input int dd);
    p = N'(pp); i = N'(ii); d = N'(dd);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic esperar_fin();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      if (periodo_fin) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout_periodo_fin: got no pulse, expected one within 1100 cycles");
    end
  endtask

  // Called at the first negedge of a period; returns at the first negedge of the next.
  task automatic medir_periodo(input int dexp, input bit blank, input string tag);
    int errs, pulsos;
    bit esp;
    errs = 0; pulsos = 0;
    for (int k = 0; k < PER; k++) begin
      esp = (k < dexp) && !(blank && (k < DT));
      if (pwm_out !== esp) errs++;
      if (periodo_fin) begin
        pulsos++;
        if (k != PER - 1) errs++;
      end
      @(negedge clk);
    end
    check({tag, "_pwm_shape_errors"}, errs, 0);
    check({tag, "_periodo_fin_pulses"}, pulsos, 1);
  endtask

  task automatic correr_vector(input vec_t v, input string tag);
    exp_t e;
    bit   blank;
    aplicar(v.pp, v.ii, v.dd);
    check({tag, "_saturado"}, int'(saturado), int'(v.sat));
    sb.push_back('{v.duty, v.dir});
    esperar_fin();
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_duty"}, int'(duty), e.duty);
    check({tag, "_dir_out"}, int'(dir_out), int'(e.dir));
    blank = DT_EN && (e.dir != prev_dir) && (e.duty != 0);
    medir_periodo(e.duty, blank, tag);
    prev_dir = e.dir;
  endtask

  initial begin
    int  cnt;
    bit  blank;

    tabla[0]  = '{300, 200, 100, 600, 1'b0, 1'b0};
    tabla[1]  = '{900, 200, 0, 1000, 1'b0, 1'b1};
    tabla[2]  = '{900, -50, 0, 850, 1'b0, 1'b0};
    tabla[3]  = '{-250, 0, 0, 250, 1'b1, 1'b0};
    tabla[4]  = '{-1000, 0, 0, 1000, 1'b1, 1'b0};
    tabla[5]  = '{-800, -500, -300, 1000, 1'b1, 1'b1};
    tabla[6]  = '{0, 0, 0, 0, 1'b0, 1'b0};
    tabla[7]  = '{262143, 262143, 262143, 1000, 1'b0, 1'b1};
    tabla[8]  = '{-262144, -262144, -262144, 1000, 1'b1, 1'b1};
    tabla[9]  = '{1, 0, -2, 1, 1'b1, 1'b0};
    tabla[10] = '{999, 0, 1, 1000, 1'b0, 1'b0};
    tabla[11] = '{500, 0, 0, 500, 1'b0, 1'b0};
    tabla[12] = '{-500, 0, 0, 500, 1'b1, 1'b0};
    tabla[13] = '{-300, 0, 0, 300, 1'b1, 1'b0};
    tabla[14] = '{-300, 0, 0, 300, 1'b1, 1'b0};

    reset = 1'b1; valid = 1'b0; p = '0; i = '0; d = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_dir_out", int'(dir_out), 0);
    check("reset_duty", int'(duty), 0);
    check("reset_saturado", int'(saturado), 0);
    check("reset_periodo_fin", int'(periodo_fin), 0);

    foreach (tabla[k]) correr_vector(tabla[k], $sformatf("vec%0d", k));

    // Valid coinciding with the wrap: the coming period keeps the old command.
    esperar_fin();
    aplicar(400, 0, 0);
    check("edge_old_duty", int'(duty), 300);
    check("edge_old_dir", int'(dir_out), 1);
    check("edge_saturado", int'(saturado), 0);
    medir_periodo(300, 1'b0, "edge_old");
    check("edge_new_duty", int'(duty), 400);
    check("edge_new_dir", int'(dir_out), 0);
    blank = DT_EN && (prev_dir != 1'b0);
    medir_periodo(400, blank, "edge_new");
    prev_dir = 1'b0;

    // Reset at counter=300 with a valid that must be ignored.
    correr_vector(tabla[0], "pre_reset");
    repeat (300) @(negedge clk);
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    reset = 1'b1;
    aplicar(-700, 0, 0);
    reset = 1'b0;
    check("rst_mid_pwm_out", int'(pwm_out), 0);
    check("rst_mid_duty", int'(duty), 0);
    check("rst_mid_dir_out", int'(dir_out), 0);
    check("rst_mid_saturado", int'(saturado), 0);
    check("rst_mid_periodo_fin", int'(periodo_fin), 0);
    cnt = 0;
    while (!periodo_fin && cnt < 1100) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_cycles_to_fin", cnt, PER - 1);
    @(negedge clk);
    check("rst_mid_valid_ignored_duty", int'(duty), 0);
    check("rst_mid_valid_ignored_dir", int'(dir_out), 0);
    medir_periodo(0, 1'b0, "rst_mid_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
